store_result_monitor: RTL and testbench

Synthesizable self-check block directly downstream of the single-cycle MIPS top level. It consumes the processor's data-memory write port (memwrite, dataadr, writedata) and classifies each store. The verdict is pass, fail or timeout. It also logs accepted stores in a small show-ahead FIFO for readout by a debug host or bench. It replaces negedge checking in simulation with a registered, sticky verdict usable on FPGA.

---
 rtl/store_result_monitor.sv | 95 +++++++++
 tb/tb_store_result_monitor.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/store_result_monitor.sv
// store_result_monitor: classifies processor stores into a sticky pass/fail/timeout verdict and logs them in a show-ahead FIFO
// Ports: clk, reset (async active-low); memwrite/dataadr/writedata store port; rd_en log pop;
//        done/pass/fail/timeout verdict; store_count; log_valid/log_addr/log_data/log_count/log_overflow log readout
module store_result_monitor #(
  parameter logic [31:0] PASS_ADDR   = 32'd84,
  parameter logic [31:0] PASS_DATA   = 32'd7,
  parameter logic [31:0] IGNORE_ADDR = 32'd80,
  parameter int          TIMEOUT     = 1024,
  parameter int          LOG_DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         memwrite,
  input  logic [31:0]                  dataadr,
  input  logic [31:0]                  writedata,
  input  logic                         rd_en,
  output logic                         done,
  output logic                         pass,
  output logic                         fail,
  output logic                         timeout,
  output logic [15:0]                  store_count,
  output logic                         log_valid,
  output logic [31:0]                  log_addr,
  output logic [31:0]                  log_data,
  output logic [$clog2(LOG_DEPTH):0]   log_count,
  output logic                         log_overflow
);
  localparam int CW = $clog2(TIMEOUT);
  localparam int PW = $clog2(LOG_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [CW-1:0] LAST_CYC = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {RUN, PASS, FAIL, TOUT} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic ovf_q, ovf_d;
  logic [31:0] mem_addr [LOG_DEPTH];
  logic [31:0] mem_data [LOG_DEPTH];
  logic run, push, pop, full, accept, hit, bad;
  always_comb begin
    run    = state_q == RUN;
    push   = run & memwrite;
    pop    = rd_en & log_valid;
    full   = lcnt_q == LW'(LOG_DEPTH);
    // a pop on the same edge frees the slot the push needs
    accept = push & (!full | pop);
    hit    = push & (dataadr == PASS_ADDR) & (writedata == PASS_DATA);
    bad    = push & (dataadr != IGNORE_ADDR);
    // a verdict-producing store on the last cycle outranks the timeout
    state_d = !run ? state_q : hit ? PASS : bad ? FAIL : (cyc_q == LAST_CYC) ? TOUT : RUN;
    cyc_d   = run ? cyc_q + 1'b1 : cyc_q;
    cnt_d   = (push && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    wr_d    = accept ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    lcnt_d  = lcnt_q + LW'(accept) - LW'(pop);
    ovf_d   = ovf_q | (push & !accept);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cyc_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      lcnt_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      lcnt_q  <= lcnt_d;
      ovf_q   <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_addr[wr_q] <= dataadr;
      mem_data[wr_q] <= writedata;
    end
  end
  assign pass         = state_q == PASS;
  assign fail         = state_q == FAIL;
  assign timeout      = state_q == TOUT;
  assign done         = pass | fail | timeout;
  assign store_count  = cnt_q;
  assign log_valid    = lcnt_q != '0;
  assign log_addr     = log_valid ? mem_addr[rd_q] : 32'd0;
  assign log_data     = log_valid ? mem_data[rd_q] : 32'd0;
  assign log_count    = lcnt_q;
  assign log_overflow = ovf_q;
endmodule

// File: tb/tb_store_result_monitor.sv
// tb_store_result_monitor: directed and randomized checks of store_result_monitor against a queue-based reference model
module tb_store_result_monitor;
  localparam int TIMEOUT = 1024;
  localparam int DEPTH = 8;
  logic clk = 0, reset = 0, memwrite = 0, rd_en = 0;
  logic [31:0] dataadr = 0, writedata = 0;
  logic done, pass, fail, timeout, log_valid, log_overflow;
  logic [15:0] store_count;
  logic [31:0] log_addr, log_data;
  logic [3:0] log_count;
  int checks = 0, errors = 0;
  int m_st, m_cyc, m_cnt;
  bit m_ovf;
  logic [63:0] q[$];
  store_result_monitor dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .rd_en(rd_en), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .store_count(store_count), .log_valid(log_valid), .log_addr(log_addr), .log_data(log_data),
    .log_count(log_count), .log_overflow(log_overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    m_st = 0; m_cyc = 0; m_cnt = 0; m_ovf = 0; q = {};
  endtask
  task automatic m_edge(input bit we, input logic [31:0] a, input logic [31:0] d, input bit rd);
    bit st, pq;
    int nxt;
    st = we && m_st == 0;
    pq = rd && q.size() > 0;
    nxt = m_st;
    if (m_st == 0) begin
      if (st && a == 84 && d == 7) nxt = 1;
      else if (st && a != 80) nxt = 2;
      else if (m_cyc == TIMEOUT - 1) nxt = 3;
      m_cyc++;
      if (st && m_cnt < 65535) m_cnt++;
    end
    if (pq) void'(q.pop_front());
    if (st) begin
      if (q.size() < DEPTH) q.push_back({a, d});
      else m_ovf = 1;
    end
    m_st = nxt;
  endtask
  task automatic check_all(input string p);
    logic [63:0] h;
    h = q.size() > 0 ? q[0] : 64'd0;
    chk({p, ".done"}, done, m_st != 0);
    chk({p, ".pass"}, pass, m_st == 1);
    chk({p, ".fail"}, fail, m_st == 2);
    chk({p, ".timeout"}, timeout, m_st == 3);
    chk({p, ".store_count"}, store_count, m_cnt);
    chk({p, ".log_valid"}, log_valid, q.size() > 0);
    chk({p, ".log_addr"}, log_addr, h[63:32]);
    chk({p, ".log_data"}, log_data, h[31:0]);
    chk({p, ".log_count"}, log_count, q.size());
    chk({p, ".log_overflow"}, log_overflow, m_ovf);
  endtask
  task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d, input bit rd, input string p);
    memwrite = we; dataadr = a; writedata = d; rd_en = rd;
    m_edge(we, a, d, rd);
    @(posedge clk); #1;
    memwrite = 0; rd_en = 0;
    check_all(p);
  endtask
  task automatic pulse_reset(input string p);
    memwrite = 0; rd_en = 0;
    #2 reset = 0;
    #1 m_reset(); check_all(p);
    #1 reset = 1;
  endtask
  initial begin
    m_reset();
    repeat (3) @(posedge clk);
    #1 check_all("rst_hold");
    #2 reset = 1;
    step(0, 0, 0, 0, "idle0");
    chk("idle0_done", done, 0);
    for (int i = 1; i < TIMEOUT - 1; i++) step(0, 0, 0, 0, "idle");
    chk("pre_tout", timeout, 0);
    step(0, 0, 0, 0, "tout_edge");
    chk("tout", timeout, 1);
    chk("tout_done", done, 1);
    step(1, 84, 7, 0, "after_tout");
    chk("tout_sticky_pass", pass, 0);
    pulse_reset("rst_a");
    step(1, 80, 1, 0, "s1");
    step(1, 80, 3, 0, "s2");
    step(1, 84, 7, 0, "s3");
    chk("pass3", pass, 1);
    chk("cnt3", store_count, 3);
    chk("lcnt3", log_count, 3);
    chk("head1_data", log_data, 1);
    step(0, 0, 0, 1, "pop1");
    chk("head2_data", log_data, 3);
    step(0, 0, 0, 1, "pop2");
    chk("head3_addr", log_addr, 84);
    step(0, 0, 0, 1, "pop3");
    chk("empty", log_valid, 0);
    step(0, 0, 0, 1, "pop_empty");
    pulse_reset("rst_b");
    step(1, 84, 6, 0, "bad");
    chk("fail", fail, 1);
    step(1, 84, 7, 0, "post_fail");
    chk("fail_sticky", fail, 1);
    chk("fail_nopass", pass, 0);
    chk("fail_cnt", store_count, 1);
    pulse_reset("rst_c");
    for (int i = 0; i < 9; i++) step(1, 80, 32'(i + 100), 0, "fill");
    chk("ovf_cnt", log_count, 8);
    chk("ovf_flag", log_overflow, 1);
    chk("ovf_head", log_data, 100);
    step(1, 80, 200, 1, "full_pushpop");
    chk("full_pp_cnt", log_count, 8);
    chk("full_pp_head", log_data, 101);
    pulse_reset("rst_d");
    step(1, 80, 5, 1, "empty_pushpop");
    chk("empty_pp_cnt", log_count, 1);
    pulse_reset("rst_e");
    for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 0, 0, "wait");
    step(1, 84, 7, 0, "edge_store");
    chk("edge_pass", pass, 1);
    chk("edge_notout", timeout, 0);
    pulse_reset("rst_f");
    step(1, 80, 11, 0, "m1");
    step(1, 80, 12, 0, "m2");
    pulse_reset("mid_rst");
    chk("mid_rst_cnt", store_count, 0);
    chk("mid_rst_valid", log_valid, 0);
    step(1, 84, 7, 0, "m3");
    chk("mid_pass", pass, 1);
    chk("mid_cnt", store_count, 1);
    for (int r = 0; r < 6; r++) begin
      pulse_reset("rst_rand");
      for (int i = 0; i < 200; i++) begin
        int sel;
        logic [31:0] a, d;
        sel = $urandom_range(0, 39);
        a = sel == 0 ? 32'd84 : sel == 1 ? $urandom_range(0, 127) : 32'd80;
        d = (sel == 0 && $urandom_range(0, 1) == 1) ? 32'd7 : $urandom_range(0, 15);
        step($urandom_range(0, 2) != 0, a, d, $urandom_range(0, 2) == 0, "rand");
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
